// File: rtl/z_pwm_pkg.sv
// ---------------------------------------------------------------------------
// z_pwm_pkg : shared levels and ramp direction encoding for the breathing PWM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package z_pwm_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // A single-frame-per-step ramp still needs a 1-bit frame register.
  function automatic int frame_w(input int fps);
    return (fps > 1) ? $clog2(fps) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/z_pwm_ramp.sv
// ---------------------------------------------------------------------------
// z_pwm_ramp : frame counter and triangle-envelope duty/direction update
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module z_pwm_ramp
  import z_pwm_pkg::*;
#(
  parameter int CNT_W           = 8,
  parameter int PERIOD          = 200,
  parameter int STEP            = 1,
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           frame_end,
  output logic [CNT_W:0] duty
);

  localparam int                 FRAME_W    = frame_w(FRAMES_PER_STEP);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES_PER_STEP - 1);
  localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);
  localparam logic [CNT_W:0]     PERIOD_D   = (CNT_W + 1)'(PERIOD);
  localparam logic [CNT_W:0]     STEP_D     = (CNT_W + 1)'(STEP);
  localparam logic [CNT_W+1:0]   PERIOD_X   = (CNT_W + 2)'(PERIOD);
  localparam logic [CNT_W+1:0]   STEP_X     = (CNT_W + 2)'(STEP);

  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [CNT_W:0]     duty_q, duty_d;
  dir_e               dir_q, dir_d;
  logic [CNT_W+1:0]   duty_up;

  always_comb begin
    frame_d = frame_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    // Extra headroom bit so duty+STEP cannot wrap before the saturation test.
    duty_up = {1'b0, duty_q} + STEP_X;
    if (en && frame_end) begin
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        if (dir_q == DIR_UP) begin
          if (duty_up >= PERIOD_X) begin
            duty_d = PERIOD_D;
            dir_d  = DIR_DOWN;
          end else begin
            duty_d = duty_up[CNT_W:0];
          end
        end else begin
          if (duty_q <= STEP_D) begin
            duty_d = '0;
            dir_d  = DIR_UP;
          end else begin
            duty_d = duty_q - STEP_D;
          end
        end
      end else begin
        frame_d = frame_q + FRAME_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
      duty_q  <= '0;
      dir_q   <= DIR_UP;
    end else begin
      frame_q <= frame_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
    end
  end

  assign duty = duty_q;

endmodule

`default_nettype wire

// File: rtl/z_pwm.sv
// ---------------------------------------------------------------------------
// z_pwm : breathing-light PWM top; period counter, duty compare, output flop
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module z_pwm
  import z_pwm_pkg::*;
#(
  parameter int CNT_W           = 8,
  parameter int PERIOD          = 200,
  parameter int STEP            = 1,
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic wave
);

  localparam logic [CNT_W:0] CNT_LAST = (CNT_W + 1)'(PERIOD - 1);
  localparam logic [CNT_W:0] CNT_ONE  = (CNT_W + 1)'(1);

  logic [CNT_W:0] cnt_q, cnt_d;
  logic           wave_q, wave_d;
  logic           frame_end;
  logic [CNT_W:0] duty;

  always_comb begin
    frame_end = en && (cnt_q == CNT_LAST);
    cnt_d     = cnt_q;
    if (en) begin
      cnt_d = frame_end ? '0 : cnt_q + CNT_ONE;
    end
    // Compare uses the duty that is current this cycle; a duty update on the
    // frame-end edge therefore only affects the following frame.
    wave_d = (en && (cnt_q < duty)) ? HIGH : LOW;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      wave_q <= LOW;
    end else begin
      cnt_q  <= cnt_d;
      wave_q <= wave_d;
    end
  end

  z_pwm_ramp #(
    .CNT_W          (CNT_W),
    .PERIOD         (PERIOD),
    .STEP           (STEP),
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_ramp (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .frame_end(frame_end),
    .duty     (duty)
  );

  assign wave = wave_q;

endmodule

`default_nettype wire

// File: tb/tb_z_pwm.sv
// ---------------------------------------------------------------------------
// tb_z_pwm : three PWM configurations driven together, checked cycle by cycle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_z_pwm;

  localparam int NDUT = 3;
  localparam int P_A [NDUT] = '{4, 4, 4};
  localparam int S_A [NDUT] = '{1, 1, 3};
  localparam int F_A [NDUT] = '{1, 3, 1};
  localparam int EXP_CNT [NDUT][9] = '{'{0, 1, 2, 3, 4, 3, 2, 1, 0},
                                       '{0, 0, 0, 1, 1, 1, 2, 2, 2},
                                       '{0, 3, 4, 1, 0, 3, 4, 1, 0}};

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [NDUT-1:0] wave;

  always #5 clk = ~clk;

  z_pwm #(.CNT_W(8), .PERIOD(4), .STEP(1), .FRAMES_PER_STEP(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .wave(wave[0]));
  z_pwm #(.CNT_W(8), .PERIOD(4), .STEP(1), .FRAMES_PER_STEP(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .wave(wave[1]));
  z_pwm #(.CNT_W(8), .PERIOD(4), .STEP(3), .FRAMES_PER_STEP(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .wave(wave[2]));

  int              checks = 0;
  int              errors = 0;
  int              n;
  int              prev_n;
  bit              prev_en;
  logic [NDUT-1:0] exp_w;
  int              hist [NDUT][64];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Duty of step k on a closed-form triangle: up in STEP increments capped
  // at PERIOD, then down capped at 0, repeating every 2*ceil(P/S) steps.
  function automatic int duty_at(input int d, input int k);
    int p, s, u, j, v;
    p = P_A[d];
    s = S_A[d];
    u = (p + s - 1) / s;
    j = (k / F_A[d]) % (2 * u);
    if (j <= u) begin
      v = j * s;
      if (v > p) v = p;
    end else begin
      v = p - (j - u) * s;
      if (v < 0) v = 0;
    end
    return v;
  endfunction

  // Expected output after the nn-th enabled cycle since reset.
  function automatic logic model_wave(input int d, input int nn);
    return ((nn % P_A[d]) < duty_at(d, nn / P_A[d]));
  endfunction

  task automatic tick(input bit en_v);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("wave%0d_n%0d", d, prev_n), {31'd0, wave[d]}, {31'd0, exp_w[d]});
      if (prev_en && prev_n < 64) hist[d][prev_n] = int'(wave[d]);
    end
    en      = en_v;
    prev_en = en_v;
    prev_n  = n;
    for (int d = 0; d < NDUT; d++) begin
      exp_w[d] = en_v ? model_wave(d, n) : 1'b0;
    end
    if (en_v) n++;
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("async_rst%0d", d), {31'd0, wave[d]}, 32'd0);
    end
    en = 1'b0;
    repeat (hold) @(negedge clk);
    rst_n   = 1'b1;
    n       = 0;
    prev_n  = 0;
    prev_en = 1'b0;
    exp_w   = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int sum;
    rst_n   = 1'b0;
    en      = 1'b0;
    n       = 0;
    prev_n  = 0;
    prev_en = 1'b0;
    exp_w   = '0;

    do_reset(3);

    // Breathing sequence with a 3-cycle pause mid-frame at duty 2.
    while (n < 10) tick(1'b1);
    repeat (3) tick(1'b0);
    while (n < 40) tick(1'b1);
    tick(1'b0);

    for (int d = 0; d < NDUT; d++) begin
      for (int f = 0; f < 9; f++) begin
        sum = 0;
        for (int c = 0; c < 4; c++) sum += hist[d][4 * f + c];
        check($sformatf("frame_high_cnt%0d_f%0d", d, f), sum, EXP_CNT[d][f]);
      end
    end

    // Reset mid-frame during the duty-3 frame, then confirm a clean restart.
    do_reset(2);
    while (n < 14) tick(1'b1);
    do_reset(2);
    while (n < 12) tick(1'b1);

    repeat (3000) begin
      if ($urandom_range(0, 399) == 0) do_reset(int'($urandom_range(1, 3)));
      else tick($urandom_range(0, 3) != 0);
    end
    tick(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
